ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, fed directly by the ID_EX pipeline register outputs after operand forwarding.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles.
- Raises a stall request so PC, IF_ID and ID_EX hold while it runs.
- Presents the result and rd for capture into EX_MEM on a one-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width; only 32 supported.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  ID/EX holds a valid M-extension op (opcode 0110011, funct7 0000001)
- op  in  3  funct3 of that op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_val  in  32  forwarded rs1 operand
- rs2_val  in  32  forwarded rs2 operand
- rd_in  in  5  destination register from ID/EX
- flush  in  1  kill in-flight op (branch taken)
- stall_req  out  1  hold PC/IF_ID/ID_EX this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse; result/rd_out valid
- result  out  32  final value
- rd_out  out  5  latched rd

Behaviour:
- Reset (async, immediate): state=IDLE, count=0, result=0, rd_out=0, done=0, busy=0; stall_req=0 while reset is high. Operand/accumulator registers are cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - If start and !flush: latch op, rd_in, and |rs1|, |rs2| per signedness (MULH/DIV/REM: both signed; MULHSU: rs1 signed only; unsigned ops: raw). Also latch result-sign flags. count=0.
  - Next state is CALC, except special cases, which go straight to DONE.
  - Special cases: div/rem by zero gives quotient 0xFFFFFFFF and remainder rs1. Signed overflow (0x80000000 / 0xFFFFFFFF) gives quotient 0x80000000 and remainder 0.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply (64-bit accumulator), restoring shift-subtract for divide.
  - count increments 0..31; at count==31 go to DONE.
- DONE:
  - Apply sign fix: negate the 64-bit product if signs differ. Quotient is negated if signs differ; remainder takes the dividend's sign.
  - Select result: MUL low word; MULH* high word; DIV* quotient; REM* remainder.
  - Register result and rd_out; done=1 for exactly this cycle. Next state is IDLE unconditionally; start is ignored in DONE, because the same instruction is still in ID/EX.
- stall_req = (state==IDLE & start & !flush) | (state==CALC). It is 0 in DONE, so the pipeline advances on the DONE edge.
- Latency:
  - Normal op: start accepted in cycle 0, CALC in cycles 1..32, done in cycle 33. stall_req is high in cycles 0..32.
  - Special case: done in cycle 1, with a 1-cycle stall.
- result/rd_out hold their last value until the next DONE.
- flush: synchronous, priority over start and state. Next state is IDLE; done is never raised for the killed op; result is unchanged.
- Back-to-back: a new start is accepted in the IDLE cycle following DONE.
- Reset mid-operation aborts immediately; no done.

Optional Feature:
- MULDIV_FAST_MUL_EN
  - Defined: multiply ops use a combinational 33x33 signed multiplier and go IDLE->DONE, giving a 1-cycle stall with done in cycle 1. Divide is unchanged.
  - Undefined: all multiplies use the 32-step iterative path.

Decomposition:
- In cpu_pkg:
  - muldiv_op_e enum (the 8 funct3 codes)
  - muldiv_state_e (IDLE, CALC, DONE)
  - MULDIV_FUNCT7 = 7'b0000001
  - XLEN constant
- Sub-module muldiv_step: combinational single radix-2 step (multiply add/shift, divide subtract/shift), instanced once in CALC datapath.

Test Plan:
- MUL 7 * 0xFFFFFFFD (-3) -> result 0xFFFFFFEB, done at cycle 33, stall_req high cycles 0..32, rd_out=rd_in.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each done at cycle 1.
- Start DIVU, assert flush at cycle 10 -> busy=0 at cycle 11, no done pulse, result unchanged; new start at cycle 11 completes normally.
- Assert reset at cycle 5 of a MUL -> result/rd_out/done/busy/stall_req 0 without waiting for a clock edge. With start held through DONE, exactly one done pulse occurs per op.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU core's RV32M multiply/divide path.
//   XLEN           : operand/result width (only 32 is supported)
//   MULDIV_FUNCT7  : funct7 value identifying an M-extension R-type op
//   muldiv_op_e    : funct3 encodings of the eight M-extension ops
//   muldiv_state_e : sequencer states of ex_muldiv_unit
// Helper functions decode operand signedness and the multiply/divide class.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic rs1_is_signed(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic rs2_is_signed(input muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 iteration of the multiply/divide datapath.
// The 2W-bit accumulator is {hi, lo}:
//   multiply : hi = partial product, lo = remaining multiplier bits;
//              add operand (multiplicand) when lo[0] is set, then shift right.
//   divide   : hi = partial remainder, lo = dividend bits / quotient bits;
//              shift left one bit, restoring-subtract operand (divisor).
// Ports:
//   is_div   in  1     select divide step (else multiply step)
//   acc_in   in  2W    current accumulator
//   operand  in  W     multiplicand or divisor magnitude
//   acc_out  out 2W    accumulator after this step
module muldiv_step #(
  parameter int unsigned W = 32
) (
  input  logic           is_div,
  input  logic [2*W-1:0] acc_in,
  input  logic [W-1:0]   operand,
  output logic [2*W-1:0] acc_out
);

  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W:0]   sum;
  logic [W:0]   shifted;
  logic [W:0]   diff;

  assign hi = acc_in[2*W-1:W];
  assign lo = acc_in[W-1:0];

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    shifted = {hi, lo[W-1]};
    diff    = shifted - {1'b0, operand};
    acc_out = '0;
    if (is_div) begin
      // The partial remainder is always below the divisor, so the shifted
      // value fits in W+1 bits and diff[W] is a clean borrow flag.
      if (!diff[W]) acc_out = {diff[W-1:0], lo[W-2:0], 1'b1};
      else          acc_out = {shifted[W-1:0], lo[W-2:0], 1'b0};
    end else begin
      // The carry out of the add becomes the new top bit after the shift.
      acc_out = {sum, lo[W-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on operand magnitudes over
// 32 cycles, holding the front of the pipeline via stall_req, then presents
// result/rd_out with a one-cycle done pulse for capture into EX_MEM.
// Optional build macro: MULDIV_FAST_MUL_EN -- multiplies use a single-cycle
// combinational 33x33 signed multiplier (IDLE->DONE); divides unchanged.
// Ports:
//   clock      in  1     system clock
//   reset      in  1     asynchronous, active-high reset
//   start      in  1     ID/EX holds a valid M-extension op
//   op         in  3     funct3 of that op
//   rs1_val    in  XLEN  forwarded rs1 operand
//   rs2_val    in  XLEN  forwarded rs2 operand
//   rd_in      in  5     destination register from ID/EX
//   flush      in  1     kill the in-flight op
//   stall_req  out 1     hold PC/IF_ID/ID_EX this cycle
//   busy       out 1     sequencer not idle
//   done       out 1     one-cycle pulse; result/rd_out valid
//   result     out XLEN  final value (held until the next done)
//   rd_out     out 5     destination register of the result
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  import cpu_pkg::*;

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = '1;
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state;
  muldiv_op_e        op_q;
  logic [4:0]        rd_q;
  logic [CW-1:0]     count;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] step_acc;
  logic              neg_res;
  logic              neg_rem;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;

  // Decode of the op waiting in ID/EX.
  muldiv_op_e      op_in;
  logic            s1;
  logic            s2;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic            div_zero;
  logic            div_ovf;
  logic            special;

  assign op_in    = muldiv_op_e'(op);
  assign s1       = rs1_is_signed(op_in) & rs1_val[XLEN-1];
  assign s2       = rs2_is_signed(op_in) & rs2_val[XLEN-1];
  assign abs1     = s1 ? (~rs1_val + 1'b1) : rs1_val;
  assign abs2     = s2 ? (~rs2_val + 1'b1) : rs2_val;
  assign div_zero = (rs2_val == '0);
  assign div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (rs1_val == MIN_INT) && (rs2_val == '1);
  assign special  = op_is_div(op_in) & (div_zero | div_ovf);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fm_a;
  logic signed [XLEN:0]     fm_b;
  logic signed [2*XLEN-1:0] fm_prod;

  assign fm_a    = {s1, rs1_val};
  assign fm_b    = {s2, rs2_val};
  assign fm_prod = fm_a * fm_b;
`endif

  muldiv_step #(.W(XLEN)) u_step (
    .is_div  (op_is_div(op_q)),
    .acc_in  (acc),
    .operand (opnd),
    .acc_out (step_acc)
  );

  // Sign fix-up and result selection, evaluated while in DONE.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    prod = neg_res ? (~acc + 1'b1) : acc;
    quot = neg_res ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem  = neg_rem ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    final_res = '0;
    unique case (op_q)
      OP_MUL:                       final_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = quot;
      default:                      final_res = rem;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_MUL;
      rd_q     <= '0;
      count    <= '0;
      opnd     <= '0;
      acc      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= op_in;
            rd_q  <= rd_in;
            count <= '0;
            if (special) begin
              // Architectural results are preloaded as {remainder, quotient}
              // with sign fix-up disabled, so DONE handles them unchanged.
              state   <= ST_DONE;
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
              acc     <= div_zero ? {rs1_val, {XLEN{1'b1}}} : {{XLEN{1'b0}}, MIN_INT};
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!op_is_div(op_in)) begin
              state   <= ST_DONE;
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
              acc     <= fm_prod;
            end
`endif
            else begin
              // Multiply: lo holds the multiplier, opnd the multiplicand.
              // Divide:   lo holds the dividend,   opnd the divisor.
              state   <= ST_CALC;
              neg_res <= s1 ^ s2;
              neg_rem <= s1;
              opnd    <= op_is_div(op_in) ? abs2 : abs1;
              acc     <= {{XLEN{1'b0}}, (op_is_div(op_in) ? abs1 : abs2)};
            end
          end
        end
        ST_CALC: begin
          acc   <= step_acc;
          count <= count + 1'b1;
          if (count == CNT_LAST) state <= ST_DONE;
        end
        ST_DONE: begin
          result_q <= final_res;
          rd_out_q <= rd_q;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE) & ~flush;
  assign result    = done ? final_res : result_q;
  assign rd_out    = done ? rd_q : rd_out_q;
  assign stall_req = ~reset & (((state == ST_IDLE) & start & ~flush) | (state == ST_CALC));

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        flush;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] last_result = '0;
  logic [4:0]  last_rd = '0;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .rd_in     (rd_in),
    .flush     (flush),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == MIN_INT && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    start   = 1'b1;
    flush   = 1'b0;
    op      = f;
    rs1_val = a;
    rs2_val = b;
    rd_in   = rd;
  endtask

  // Called in cycle 0 (after issue); start stays held through DONE.
  task automatic wait_done(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
    int          lat;
    int          stalls;
    logic [31:0] exp;
    exp    = ref_res(f, a, b);
    lat    = 0;
    stalls = 0;
    @(negedge clock);
    check({tag, " busy@0"}, busy, 0);
    stalls += int'(stall_req);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock);
      #1;
      @(negedge clock);
      stalls += int'(stall_req);
      if (done) begin
        lat = c;
        break;
      end
    end
    check({tag, " latency"}, lat, exp_lat(f, a, b));
    check({tag, " stall_cycles"}, stalls, exp_lat(f, a, b));
    check({tag, " result"}, result, exp);
    check({tag, " rd_out"}, rd_out, rd);
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    check({tag, " single_done"}, done, 0);
    check({tag, " result_hold"}, result, exp);
    last_result = exp;
    last_rd     = rd;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    @(posedge clock);
    #1;
    issue(f, a, b, rd);
    wait_done(tag, f, a, b, rd);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return MIN_INT;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          dcnt;
    logic [31:0] prev;
    reset   = 1'b1;
    flush   = 1'b0;
    start   = 1'b1;
    op      = 3'd0;
    rs1_val = 32'd3;
    rs2_val = 32'd4;
    rd_in   = 5'd1;
    #1;
    check("reset stall_req", stall_req, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset rd_out", rd_out, 0);
    start = 1'b0;
    #20;
    reset = 1'b0;

    run_op("MUL 7*-3",      3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    run_op("MULH min*min",  3'd1, MIN_INT, MIN_INT, 5'd6);
    run_op("MULHU -1*-1",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    run_op("MULHSU -1*-1",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
    run_op("DIV -7/2",      3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9);
    run_op("REM -7/2",      3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10);
    run_op("DIVU 100/7",    3'd5, 32'd100, 32'd7, 5'd11);
    run_op("REMU 100/7",    3'd7, 32'd100, 32'd7, 5'd12);
    run_op("DIV 5/0",       3'd4, 32'd5, 32'd0, 5'd13);
    run_op("REM 5/0",       3'd6, 32'd5, 32'd0, 5'd14);
    run_op("DIV ovf",       3'd4, MIN_INT, 32'hFFFF_FFFF, 5'd15);
    run_op("REM ovf",       3'd6, MIN_INT, 32'hFFFF_FFFF, 5'd16);
    run_op("REMU 100/7 b",  3'd7, 32'd100, 32'd7, 5'd17);

    // Flush a DIVU in cycle 10; a new op starts in cycle 11.
    prev = last_result;
    @(posedge clock);
    #1;
    issue(3'd5, 32'd1000, 32'd7, 5'd20);
    dcnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock);
      #1;
      if (c == 10) flush = 1'b1;
      @(negedge clock);
      dcnt += int'(done);
    end
    @(posedge clock);
    #1;
    issue(3'd5, 32'd123456, 32'd321, 5'd21);
    #1;
    check("flush no_done", dcnt, 0);
    check("flush busy", busy, 0);
    check("flush result_kept", result, prev);
    check("flush rd_kept", rd_out, last_rd);
    wait_done("after_flush DIVU", 3'd5, 32'd123456, 32'd321, 5'd21);

    // Reset in cycle 5 of a MUL clears outputs without a clock edge.
    @(posedge clock);
    #1;
    issue(3'd0, 32'd1234, 32'd5678, 5'd22);
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("midreset result", result, 0);
    check("midreset rd_out", rd_out, 0);
    check("midreset done", done, 0);
    check("midreset busy", busy, 0);
    check("midreset stall_req", stall_req, 0);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(negedge clock);
      dcnt += int'(done);
    end
    check("midreset no_done", dcnt, 0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      logic [4:0]  rd;
      f  = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      rd = 5'($urandom);
      run_op($sformatf("rand%0d op%0d", i, f), f, a, b, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
